// File: rtl/ifq_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package ifq_pkg;

  localparam int          IFQ_DEPTH_DEF = 4;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [31:0] MIPS_NOP      = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:2] pc;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Ring buffer of fetched instruction/PC pairs with push, pop and flush.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  ifq_entry_t               push_entry,
  output ifq_entry_t               head_entry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  ifq_entry_t    mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Flush wins over everything; a push into a full buffer is accepted only alongside a pop.
  always_comb begin
    do_pop  = pop && !flush && (count_q != '0);
    do_push = push && !flush && ((count_q != FULL) || do_pop);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_pop)  head_d = head_q + 1'b1;
      if (do_push) tail_d = tail_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= push_entry;
  end

  assign head_entry = mem_q[head_q];
  assign count      = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the fetch PC, reads a synchronous instruction memory and buffers words.
// Define IFQ_BYPASS_EN to forward a response straight to the outputs when the queue is empty.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = IFQ_DEPTH_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IM_AW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  output logic             im_req,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_rdata,
  input  logic             redirect,
  input  logic [29:0]      redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      instruction,
  output logic [29:0]      inst_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [29:0] RESET_FPC = RESET_PC[31:2];

  logic [29:0]   fpc_q, fpc_d;
  logic [29:0]   tag_q, tag_d;
  logic [29:0]   last_pc_q, last_pc_d;
  logic          inflight_q, inflight_d;
  logic          drop_q, drop_d;
  logic [CW-1:0] cnt;
  logic [CW:0]   occupancy;
  logic          rsp_ok, bypass;
  logic          fifo_push, fifo_pop;
  ifq_entry_t    push_entry, head_entry;

  assign occupancy = {1'b0, cnt} + {{CW{1'b0}}, inflight_q};
  assign im_req    = !reset && !redirect && (occupancy < DEPTH_W);
  assign im_addr   = fpc_q[IM_AW-1:0];

  // A response lands the cycle after its request; redirect discards it outright.
  always_comb begin
    rsp_ok = inflight_q && !drop_q && !redirect;
`ifdef IFQ_BYPASS_EN
    bypass = rsp_ok && (cnt == '0);
`else
    bypass = 1'b0;
`endif
    fifo_push        = rsp_ok && !(bypass && inst_ready);
    fifo_pop         = inst_ready && (cnt != '0);
    push_entry.instr = im_rdata;
    push_entry.pc    = tag_q;
  end

  always_comb begin
    inst_valid  = 1'b0;
    instruction = MIPS_NOP;
    inst_pc     = last_pc_q;
    if (cnt != '0) begin
      inst_valid  = 1'b1;
      instruction = head_entry.instr;
      inst_pc     = head_entry.pc;
    end else if (bypass) begin
      inst_valid  = 1'b1;
      instruction = im_rdata;
      inst_pc     = tag_q;
    end
  end

  // The memory answers inside the redirect cycle itself, so no stale word survives past it.
  always_comb begin
    fpc_d      = fpc_q;
    tag_d      = tag_q;
    inflight_d = im_req;
    drop_d     = inflight_q ? 1'b0 : drop_q;
    last_pc_d  = inst_valid ? inst_pc : last_pc_q;
    if (redirect) begin
      fpc_d  = redirect_pc;
      drop_d = 1'b0;
    end else if (im_req) begin
      fpc_d = fpc_q + 30'd1;
      tag_d = fpc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q      <= RESET_FPC;
      tag_q      <= RESET_FPC;
      last_pc_q  <= RESET_FPC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      tag_q      <= tag_d;
      last_pc_q  <= last_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .count      (cnt)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue; memory word i holds the value i.
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        reset;
  logic        im_req;
  logic [9:0]  im_addr;
  logic [31:0] im_rdata;
  logic        redirect;
  logic [29:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [29:0] inst_pc;

  int vectors;
  int miscompares;
  int reqs;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_3000), .IM_AW(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_rdata    (im_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .instruction (instruction),
    .inst_pc     (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (im_req) im_rdata <= 32'(im_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic rdr, input logic [29:0] rpc);
    inst_ready  = rdy;
    redirect    = rdr;
    redirect_pc = rpc;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse reset and release it #1 after a rising edge; the caller is then in cycle 0.
  task automatic restart(input logic rdy);
    applyStimulus(rdy, 1'b0, 30'h0);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    im_rdata    = 32'h0;
    applyStimulus(1'b1, 1'b0, 30'h0);
    reset = 1'b1;
    repeat (2) tick();

    checkOutput("rst_im_req", 32'(im_req), 32'd0);
    checkOutput("rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_instr", instruction, 32'h0);
    checkOutput("rst_pc", 32'(inst_pc), 32'h0C00);

    $display("[TB] streaming with ready held high");
    reset = 1'b0;
    #1;
    checkOutput("c0_im_req", 32'(im_req), 32'd1);
    checkOutput("c0_addr", 32'(im_addr), 32'h0);
    checkOutput("c0_valid", 32'(inst_valid), 32'd0);
    for (int c = 1; c < 8; c++) begin
      tick();
      checkOutput("stream_addr", 32'(im_addr), 32'(c));
      checkOutput("stream_valid", 32'(inst_valid), 32'(c >= LAT));
      if (c >= LAT) begin
        checkOutput("stream_pc", 32'(inst_pc), 32'h0C00 + 32'(c - LAT));
        checkOutput("stream_instr", instruction, 32'(c - LAT));
      end
    end

    $display("[TB] stall for ten cycles then drain");
    restart(1'b0);
    reqs = 0;
    for (int c = 0; c < 10; c++) begin
      reqs += int'(im_req);
      tick();
    end
    checkOutput("full_reqs", 32'(reqs), 32'd4);
    checkOutput("full_im_req", 32'(im_req), 32'd0);
    checkOutput("full_valid", 32'(inst_valid), 32'd1);
    applyStimulus(1'b1, 1'b0, 30'h0);
    for (int k = 0; k < 6; k++) begin
      checkOutput("drain_valid", 32'(inst_valid), 32'd1);
      checkOutput("drain_pc", 32'(inst_pc), 32'h0C00 + 32'(k));
      checkOutput("drain_instr", instruction, 32'(k));
      tick();
    end

    $display("[TB] redirect with three queued and one in flight");
    restart(1'b0);
    repeat (4) tick();
    checkOutput("pre_rdr_valid", 32'(inst_valid), 32'd1);
    checkOutput("pre_rdr_im_req", 32'(im_req), 32'd0);
    applyStimulus(1'b0, 1'b1, 30'h0C40);
    #1;
    checkOutput("rdr_im_req", 32'(im_req), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 30'h0);
    #1;
    checkOutput("rdr1_valid", 32'(inst_valid), 32'd0);
    checkOutput("rdr1_im_req", 32'(im_req), 32'd1);
    checkOutput("rdr1_addr", 32'(im_addr), 32'h040);
    checkOutput("rdr1_pc_hold", 32'(inst_pc), 32'h0C00);
    tick();
    checkOutput("rdr2_valid", 32'(inst_valid), 32'(LAT == 1));
    tick();
    checkOutput("rdr3_valid", 32'(inst_valid), 32'd1);
    checkOutput("rdr3_pc", 32'(inst_pc), 32'h0C40);
    checkOutput("rdr3_instr", instruction, 32'h40);
    applyStimulus(1'b1, 1'b0, 30'h0);
    tick();
    checkOutput("rdr4_pc", 32'(inst_pc), 32'h0C41);
    checkOutput("rdr4_instr", instruction, 32'h41);

    $display("[TB] redirect together with a pop");
    restart(1'b0);
    repeat (2) tick();
    checkOutput("pop_pre_valid", 32'(inst_valid), 32'd1);
    applyStimulus(1'b1, 1'b1, 30'h0D00);
    #1;
    checkOutput("pop_rdr_im_req", 32'(im_req), 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 30'h0);
    #1;
    checkOutput("pop_rdr1_valid", 32'(inst_valid), 32'd0);
    repeat (LAT) tick();
    checkOutput("pop_new_valid", 32'(inst_valid), 32'd1);
    checkOutput("pop_new_pc", 32'(inst_pc), 32'h0D00);
    checkOutput("pop_new_instr", instruction, 32'h100);

    $display("[TB] reset asserted with two entries queued");
    restart(1'b0);
    repeat (3) tick();
    checkOutput("mid_pre_valid", 32'(inst_valid), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_im_req", 32'(im_req), 32'd0);
    checkOutput("mid_valid", 32'(inst_valid), 32'd0);
    checkOutput("mid_instr", instruction, 32'h0);
    checkOutput("mid_pc", 32'(inst_pc), 32'h0C00);
    checkOutput("mid_addr", 32'(im_addr), 32'h0);
    tick();
    checkOutput("mid_hold_im_req", 32'(im_req), 32'd0);
    checkOutput("mid_hold_valid", 32'(inst_valid), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("mid_rel_im_req", 32'(im_req), 32'd1);
    checkOutput("mid_rel_addr", 32'(im_addr), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch stage with prefetch buffer, sitting directly upstream of the single-cycle datapath. Owns the fetch PC, issues word reads to a synchronous instruction memory, and buffers returned instructions with their PCs in a small FIFO. Presents one instruction at a time to the datapath over a valid/ready handshake. A redirect from branch/jump resolution flushes the buffer and restarts fetch at the new PC.

## Interface
- DEPTH, 4: queue entries; power of two, ≥ 2.
- RESET_PC, 32'h0000_3000: first fetch address; bits [1:0] must be 0.
- IM_AW, 10: instruction memory word-address width.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- im_req  out  1  read strobe to instruction memory.
- im_addr  out  IM_AW  word address, fetch PC[IM_AW+1:2].
- im_rdata  in  32  read data, valid exactly one cycle after im_req.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  30  new fetch PC [31:2].
- inst_valid  out  1  head entry present.
- inst_ready  in  1  datapath consumes head this cycle.
- instruction  out  32  head instruction word.
- inst_pc  out  30  PC [31:2] of head instruction.

## Operation
- State: fetch PC fpc[31:2], inflight flag, drop flag, queue count cnt (0..DEPTH).
- Issue: im_req = !reset && (cnt + inflight + push_this_cycle... simplified: cnt + inflight < DEPTH). On im_req, fpc ← fpc+1 (word increment, wraps at 2^30), inflight ← 1, and the issued PC is held in a tag register.
- Return: cycle after im_req, im_rdata with tag PC pushed into queue unless drop is set; drop is cleared on return.
- Pop: inst_valid && inst_ready removes head.
- Simultaneous push and pop: cnt unchanged; permitted when full.
- Redirect (highest priority): cnt ← 0, fpc ← redirect_pc, drop ← inflight (in-flight response discarded), any same-cycle pop/push ignored; im_req is 0 in the redirect cycle. Fetch restarts next cycle.
- No interpretation of opcodes; branches, delay slots and hazards are the datapath's concern.
- inst_valid = (cnt ≠ 0); when 0, instruction drives 32'h0000_0000 (MIPS nop) and inst_pc holds last value.

## Timing
- Reset values: fpc = RESET_PC[31:2], cnt = 0, inflight = 0, drop = 0, im_req = 0, inst_valid = 0, instruction = 0, inst_pc = RESET_PC[31:2].
- First im_req in first clock after reset deasserts (cycle 0).
- Latency without bypass: request cycle N, data cycle N+1, inst_valid at N+2.
- Steady state: one instruction per cycle when inst_ready held high.
- Full (cnt = DEPTH, no in-flight): im_req low until a pop.
- Redirect at cycle R: first new instruction valid at R+3 (R+2 with bypass).
- Reset mid-operation: all state returns to reset values asynchronously; in-flight response ignored.

## Configuration
- IFQ_BYPASS_EN defined: when cnt = 0 and a non-dropped response returns, im_rdata and tag PC drive instruction/inst_pc combinationally with inst_valid = 1 in the same cycle; if inst_ready, the entry is not written. Latency drops to 1 cycle after request.
- Undefined: all responses go through queue storage; outputs purely registered.

## Structure
- Package ifq_pkg: IFQ_DEPTH_DEF, RESET_PC_DEF, MIPS_NOP constant, ifq_entry_t typedef {instr[31:0], pc[31:2]}.
- One sub-module ifq_fifo: DEPTH-entry ring buffer of ifq_entry_t with push/pop/flush, head/tail pointers with wrap, count output.

## Test plan
- Reset release, inst_ready=1, memory holds word i = i: im_addr 0x000,0x001,...; inst_pc 0x0C00,0x0C01...; inst_valid first at cycle 2, then every cycle.
- inst_ready=0 for 10 cycles: exactly DEPTH=4 requests issued, cnt=4, im_req low; release ready -> 4 buffered words in order, no gap or duplicate.
- Redirect to 30'h0C40 while inflight and cnt=3: queue empty next cycle, in-flight word dropped, next instruction delivered has inst_pc 0x0C40.
- Redirect and pop in same cycle with cnt=1: popped entry ignored, cnt=0, no spurious inst_valid.
- Assert reset while cnt=2: outputs return to reset values immediately, no im_req during reset.
- IFQ_BYPASS_EN build: from empty queue, inst_valid asserted cycle 1 after reset release with instruction = im_rdata.
